// File: rtl/if_pc_stage.sv
// Instruction-fetch stage: owns the PC and the IF/ID register, applies redirects and
// load-use stalls, raises the ID/EX flush, and keeps saturating event counters.
module if_pc_stage #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter logic [31:0] NOP_INST = 32'h0000_0013,
   parameter int unsigned CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             npc_op,
   input  logic [31:0]      npc_result,
   input  logic             stall,
   input  logic [31:0]      irom_inst,
   output logic [31:0]      irom_addr,
   output logic [31:0]      id_pc,
   output logic [31:0]      id_pc4,
   output logic [31:0]      id_inst,
   output logic             id_valid,
   output logic             flush_idex,
   output logic             misalign_err,
   output logic [CNT_W-1:0] redirect_cnt,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int unsigned XLEN = 32;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] pc4;
      logic [XLEN-1:0] inst;
      logic            valid;
   } ifid_t;

   localparam ifid_t IFID_BUBBLE = '{pc: '0, pc4: '0, inst: NOP_INST, valid: 1'b0};

   logic [XLEN-1:0]  pc_q, pc_d;
   logic [XLEN-1:0]  pc_plus4;
   logic [XLEN-1:0]  redirect_pc;
   ifid_t            ifid_q, ifid_d;
   logic             mis_q, mis_d;
   logic [CNT_W-1:0] rcnt_q, rcnt_d;
   logic [CNT_W-1:0] scnt_q, scnt_d;
   logic             unused_npc_bit0;

   // Redirect targets are forced word-aligned; bit 1 only feeds the sticky error flag.
   assign pc_plus4        = pc_q + XLEN'(4);
   assign redirect_pc     = {npc_result[XLEN-1:2], 2'b00};
   assign unused_npc_bit0 = npc_result[0];

   // Next-state: redirect beats stall beats normal advance.
   always_comb begin
      pc_d   = pc_q;
      ifid_d = ifid_q;
      mis_d  = mis_q;
      rcnt_d = rcnt_q;
      scnt_d = scnt_q;
      if (npc_op) begin
         pc_d   = redirect_pc;
         ifid_d = IFID_BUBBLE;
         if (npc_result[1]) begin
            mis_d = 1'b1;
         end
         if (rcnt_q != CNT_MAX) begin
            rcnt_d = rcnt_q + CNT_W'(1);
         end
      end else if (stall) begin
         if (scnt_q != CNT_MAX) begin
            scnt_d = scnt_q + CNT_W'(1);
         end
      end else begin
         pc_d   = pc_plus4;
         ifid_d = '{pc: pc_q, pc4: pc_plus4, inst: irom_inst, valid: 1'b1};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q   <= RESET_PC;
         ifid_q <= IFID_BUBBLE;
         mis_q  <= 1'b0;
         rcnt_q <= '0;
         scnt_q <= '0;
      end else begin
         pc_q   <= pc_d;
         ifid_q <= ifid_d;
         mis_q  <= mis_d;
         rcnt_q <= rcnt_d;
         scnt_q <= scnt_d;
      end
   end

   // The flush must reach ID/EX at the same edge the redirect lands, so it is unregistered.
   assign flush_idex   = npc_op;
   assign irom_addr    = pc_q;
   assign id_pc        = ifid_q.pc;
   assign id_pc4       = ifid_q.pc4;
   assign id_inst      = ifid_q.inst;
   assign id_valid     = ifid_q.valid;
   assign misalign_err = mis_q;
   assign redirect_cnt = rcnt_q;
   assign stall_cnt    = scnt_q;

endmodule

// File: tb/tb_if_pc_stage.sv
// Bench for if_pc_stage: directed scenarios with literal expectations, then randomized
// traffic compared every cycle against a behavioural fetch model.
module tb_if_pc_stage;

   localparam logic [31:0] NOP = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        npc_op;
   logic [31:0] npc_result;
   logic        stall;
   logic [31:0] irom_inst;

   logic [31:0] irom_addr, id_pc, id_pc4, id_inst;
   logic        id_valid, flush_idex, misalign_err;
   logic [15:0] redirect_cnt, stall_cnt;

   logic [31:0] s_irom_addr, s_id_pc, s_id_pc4, s_id_inst;
   logic        s_id_valid, s_flush_idex, s_misalign_err;
   logic [1:0]  s_redirect_cnt, s_stall_cnt;

   int pass_cnt  = 0;
   int check_cnt = 0;
   bit rom_mode  = 1'b0;
   bit mvalid    = 1'b0;

   // Reference state
   logic [31:0] m_pc, m_id_pc, m_id_pc4, m_id_inst;
   logic        m_id_valid, m_mis;
   int          m_rcnt, m_scnt;

   always #5 clk = ~clk;

   function automatic logic [31:0] rom(input bit mode, input logic [31:0] a);
      return mode ? ((a * 32'h9E37_79B1) ^ 32'h1234_5677) : 32'h0010_0093;
   endfunction

   function automatic int sat(input int c, input int w);
      int mx;
      mx = (1 << w) - 1;
      return (c > mx) ? mx : c;
   endfunction

   assign irom_inst = rom(rom_mode, irom_addr);

   if_pc_stage dut (
      .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .npc_result(npc_result),
      .stall(stall), .irom_inst(irom_inst), .irom_addr(irom_addr),
      .id_pc(id_pc), .id_pc4(id_pc4), .id_inst(id_inst), .id_valid(id_valid),
      .flush_idex(flush_idex), .misalign_err(misalign_err),
      .redirect_cnt(redirect_cnt), .stall_cnt(stall_cnt)
   );

   if_pc_stage #(.CNT_W(2)) dut_sat (
      .clk(clk), .rst_n(rst_n), .npc_op(npc_op), .npc_result(npc_result),
      .stall(stall), .irom_inst(irom_inst), .irom_addr(s_irom_addr),
      .id_pc(s_id_pc), .id_pc4(s_id_pc4), .id_inst(s_id_inst), .id_valid(s_id_valid),
      .flush_idex(s_flush_idex), .misalign_err(s_misalign_err),
      .redirect_cnt(s_redirect_cnt), .stall_cnt(s_stall_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      check_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
   endtask

   // Behavioural model: the fetched word is whatever the ROM holds at the model's PC.
   always @(posedge clk) begin
      if (!rst_n) begin
         m_pc = 32'h0; m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_id_inst = NOP;
         m_id_valid = 1'b0; m_mis = 1'b0; m_rcnt = 0; m_scnt = 0;
      end else if (npc_op) begin
         m_pc = npc_result & ~32'h3;
         m_id_pc = 32'h0; m_id_pc4 = 32'h0; m_id_inst = NOP; m_id_valid = 1'b0;
         m_mis = m_mis | npc_result[1];
         m_rcnt++;
      end else if (stall) begin
         m_scnt++;
      end else begin
         m_id_pc = m_pc; m_id_pc4 = m_pc + 32'd4; m_id_inst = rom(rom_mode, m_pc);
         m_id_valid = 1'b1;
         m_pc = m_pc + 32'd4;
      end
      mvalid = 1'b1;
   end

   always @(negedge clk) begin
      if (mvalid) begin
         chk("irom_addr", irom_addr, m_pc);
         chk("id_pc", id_pc, m_id_pc);
         chk("id_pc4", id_pc4, m_id_pc4);
         chk("id_inst", id_inst, m_id_inst);
         chk("id_valid", 32'(id_valid), 32'(m_id_valid));
         chk("flush_idex", 32'(flush_idex), 32'(npc_op));
         chk("misalign_err", 32'(misalign_err), 32'(m_mis));
         chk("redirect_cnt", 32'(redirect_cnt), 32'(sat(m_rcnt, 16)));
         chk("stall_cnt", 32'(stall_cnt), 32'(sat(m_scnt, 16)));
         chk("sat_irom_addr", s_irom_addr, m_pc);
         chk("sat_redirect_cnt", 32'(s_redirect_cnt), 32'(sat(m_rcnt, 2)));
         chk("sat_stall_cnt", 32'(s_stall_cnt), 32'(sat(m_scnt, 2)));
      end
   end

   task automatic cyc(input int n = 1);
      repeat (n) @(posedge clk);
      #1;
   endtask

   initial begin
      logic [31:0] r;
      rst_n = 1'b0; npc_op = 1'b0; stall = 1'b0; npc_result = 32'h0;
      cyc(2);
      rst_n = 1'b1;
      chk("lit_reset_addr", irom_addr, 32'h0);
      chk("lit_reset_valid", 32'(id_valid), 32'h0);
      chk("lit_reset_inst", id_inst, NOP);
      chk("lit_reset_cnt", 32'(stall_cnt) + 32'(redirect_cnt), 32'h0);
      cyc();
      chk("lit_run_addr4", irom_addr, 32'h4);
      chk("lit_run_id_pc", id_pc, 32'h0);
      chk("lit_run_id_inst", id_inst, 32'h0010_0093);
      chk("lit_run_valid", 32'(id_valid), 32'h1);
      cyc();
      chk("lit_run_addr8", irom_addr, 32'h8);
      stall = 1'b1;
      cyc(3);
      stall = 1'b0;
      chk("lit_stall_addr", irom_addr, 32'h8);
      chk("lit_stall_id_pc", id_pc, 32'h4);
      chk("lit_stall_cnt", 32'(stall_cnt), 32'd3);
      cyc();
      chk("lit_release_addr", irom_addr, 32'hC);
      npc_op = 1'b1; npc_result = 32'h40;
      #1 chk("lit_flush", 32'(flush_idex), 32'h1);
      cyc();
      npc_op = 1'b0;
      chk("lit_redir_addr", irom_addr, 32'h40);
      chk("lit_redir_inst", id_inst, NOP);
      chk("lit_redir_valid", 32'(id_valid), 32'h0);
      chk("lit_redir_cnt", 32'(redirect_cnt), 32'd1);
      cyc();
      chk("lit_target_id_pc", id_pc, 32'h40);
      chk("lit_target_valid", 32'(id_valid), 32'h1);
      npc_op = 1'b1; stall = 1'b1; npc_result = 32'h80;
      cyc();
      npc_op = 1'b0; stall = 1'b0;
      chk("lit_both_addr", irom_addr, 32'h80);
      chk("lit_both_stall_cnt", 32'(stall_cnt), 32'd3);
      chk("lit_both_redir_cnt", 32'(redirect_cnt), 32'd2);
      npc_op = 1'b1; npc_result = 32'h0000_0106;
      cyc();
      npc_op = 1'b0;
      chk("lit_mis_addr", irom_addr, 32'h104);
      chk("lit_mis_set", 32'(misalign_err), 32'h1);
      cyc(10);
      chk("lit_mis_sticky", 32'(misalign_err), 32'h1);
      rst_n = 1'b0; npc_op = 1'b1; stall = 1'b1; npc_result = 32'h200;
      cyc();
      rst_n = 1'b1; npc_op = 1'b0;
      chk("lit_rst_override_addr", irom_addr, 32'h0);
      chk("lit_rst_mis_clr", 32'(misalign_err), 32'h0);
      chk("lit_rst_stall_cnt", 32'(stall_cnt), 32'h0);
      cyc(5);
      stall = 1'b0;
      chk("lit_sat_stall", 32'(s_stall_cnt), 32'd3);
      chk("lit_wide_stall", 32'(stall_cnt), 32'd5);
      npc_op = 1'b1; npc_result = 32'hFFFF_FFFC;
      cyc();
      npc_op = 1'b0;
      chk("lit_wrap_pre", irom_addr, 32'hFFFF_FFFC);
      cyc();
      chk("lit_wrap_addr", irom_addr, 32'h0);
      chk("lit_wrap_id_pc4", id_pc4, 32'h0);

      rom_mode = 1'b1;
      for (int i = 0; i < 3000; i++) begin
         rst_n  = ($urandom_range(0, 99) != 0);
         npc_op = ($urandom_range(0, 4) == 0);
         stall  = ($urandom_range(0, 3) == 0);
         r = $urandom;
         if ($urandom_range(0, 9) != 0) r[1] = 1'b0;
         npc_result = r;
         cyc();
      end
      npc_op = 1'b0; stall = 1'b0;
      cyc(2);
      $display("%0d/%0d checks passed", pass_cnt, check_cnt);
      $finish;
   end

endmodule
